wb_port_arbiter: RTL and testbench

//  Shares the single register-file write port between the in-order writeback stage (primary) and

---
 rtl/temp_storage_pkg.sv | 26 ++
 rtl/wb_result_fifo.sv | 67 ++++++
 rtl/wb_port_arbiter.sv | 139 +++++++++++++
 tb/tb_wb_port_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/temp_storage_pkg.sv
// Shared register-writer payload, arbiter state encoding and register-file constants.
package temp_storage;

    localparam int unsigned REG_NUM    = 32;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned REG_DATA_W = 64;

    // One register-file write request (70 bits).
    typedef struct packed {
        logic                  reg_write_enable;
        logic [REG_ADDR_W-1:0] reg_dest_addr;
        logic [REG_DATA_W-1:0] reg_write_data;
    } reg_writer;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        FORCE = 2'd2
    } wb_arb_state_e;

    // A request only changes architectural state if enabled and not aimed at x0.
    function automatic logic writes_reg(input reg_writer w);
        return w.reg_write_enable && (w.reg_dest_addr != REG_ADDR_W'(0));
    endfunction

endpackage

// File: rtl/wb_result_fifo.sv
// Synchronous FIFO of register-writer entries; head is only visible after the push edge.
module wb_result_fifo
    import temp_storage::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         push_i,
    input  reg_writer                    push_data_i,
    input  logic                         pop_i,
    output reg_writer                    head_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    reg_writer          mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q,  count_d;
    logic               do_push, do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == CNT_W'(0));
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Pointer and occupancy bookkeeping; depth is a power of two so pointers wrap naturally.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are don't-care until the pointer logic marks them valid.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: primary writeback wins, secondary results queue and drain
// into idle cycles, and a starvation FSM requests a writeback bubble for a long-waiting head.
module wb_port_arbiter
    import temp_storage::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned MAX_WAIT   = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               pri_valid,
    input  reg_writer          pri_writer,
    input  logic               sec_valid,
    input  reg_writer          sec_writer,
    output logic               sec_ready,
    output reg_writer          rf_writer,
    output logic               sec_commit,
    output logic               stall_req,
    output logic [REG_NUM-1:0] pending_mask
);

    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT - 1);

    wb_arb_state_e      state_q, state_d;
    logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic               stall_req_q, stall_req_d;
    logic [REG_NUM-1:0] mask_q, mask_d;

    logic               pri_hit;
    logic               push, pop, fifo_empties;
    logic               fifo_full, fifo_empty;
    logic [CNT_W-1:0]   fifo_count;
    reg_writer          fifo_head;

    assign pri_hit      = pri_valid && writes_reg(pri_writer);
    assign sec_ready    = reset && !fifo_full;
    assign push         = sec_valid && sec_ready && writes_reg(sec_writer);
    assign pop          = reset && !pri_hit && !fifo_empty;
    assign fifo_empties = pop && !push && (fifo_count == CNT_W'(1));

    assign stall_req    = stall_req_q;
    assign pending_mask = mask_q;

    wb_result_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i       (clk),
        .rst_ni      (reset),
        .push_i      (push),
        .push_data_i (sec_writer),
        .pop_i       (pop),
        .head_o      (fifo_head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

    // Port select: primary first, then queue head, otherwise no write.
    always_comb begin
        rf_writer  = '0;
        sec_commit = 1'b0;
        if (reset) begin
            if (pri_hit) begin
                rf_writer = pri_writer;
            end else if (!fifo_empty) begin
                rf_writer  = fifo_head;
                sec_commit = 1'b1;
            end
        end
    end

    // FSM state register, wait counter and registered stall request.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            wait_cnt_q  <= '0;
            stall_req_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            stall_req_q <= stall_req_d;
        end
    end

    // FSM next state: leave IDLE on push, escalate to FORCE after MAX_WAIT unserved cycles.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (push) state_d = DRAIN;
            end
            DRAIN: begin
                if (pop)                           state_d = fifo_empties ? IDLE : DRAIN;
                else if (wait_cnt_q == WAIT_LIMIT) state_d = FORCE;
            end
            FORCE: begin
                if (pop) state_d = fifo_empties ? IDLE : DRAIN;
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: saturating wait counter cleared on every pop, stall while in FORCE.
    always_comb begin
        wait_cnt_d  = wait_cnt_q;
        stall_req_d = (state_d == FORCE);
        if ((state_d == IDLE) || pop) begin
            wait_cnt_d = '0;
        end else if ((state_q != IDLE) && (wait_cnt_q != '1)) begin
            wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
    end

    // Pending mask: clear the committed head's rd, then mark the newly queued rd.
    always_comb begin
        mask_d = mask_q;
        if (pop)  mask_d[fifo_head.reg_dest_addr]  = 1'b0;
        if (push) mask_d[sec_writer.reg_dest_addr] = 1'b1;
    end

    // Pending mask register.
    always_ff @(posedge clk) begin
        if (!reset) mask_q <= '0;
        else        mask_q <= mask_d;
    end

    // Interlock contract: no duplicate queued rd and no primary WAW over a queued rd.
    always @(posedge clk) begin
        if (reset) begin
            assert (!(push && mask_q[sec_writer.reg_dest_addr]))
                else $error("secondary push to x%0d while already pending", sec_writer.reg_dest_addr);
            assert (!(pri_hit && mask_q[pri_writer.reg_dest_addr]))
                else $error("primary write to x%0d while secondary write pending", pri_writer.reg_dest_addr);
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: directed scenarios plus a randomized run against a
// queue-based reference model.
module tb_wb_port_arbiter;
    import temp_storage::*;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned MW    = 8;
    localparam reg_writer   NOWR  = '0;

    logic               clk;
    logic               reset;
    logic               pri_valid;
    reg_writer          pri_writer;
    logic               sec_valid;
    reg_writer          sec_writer;
    logic               sec_ready;
    reg_writer          rf_writer;
    logic               sec_commit;
    logic               stall_req;
    logic [REG_NUM-1:0] pending_mask;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: queued secondary writes in order, and cycles the queue went unserved.
    reg_writer mq[$];
    int        unserved = 0;

    wb_port_arbiter #(
        .FIFO_DEPTH (DEPTH),
        .MAX_WAIT   (MW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .pri_valid    (pri_valid),
        .pri_writer   (pri_writer),
        .sec_valid    (sec_valid),
        .sec_writer   (sec_writer),
        .sec_ready    (sec_ready),
        .rf_writer    (rf_writer),
        .sec_commit   (sec_commit),
        .stall_req    (stall_req),
        .pending_mask (pending_mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    function automatic reg_writer mk(input bit en, input int unsigned rd, input logic [63:0] d);
        reg_writer w;
        w.reg_write_enable = en;
        w.reg_dest_addr    = 5'(rd);
        w.reg_write_data   = d;
        return w;
    endfunction

    function automatic logic [63:0] rnd64();
        return {32'($urandom), 32'($urandom)};
    endfunction

    function automatic bit m_writes(input reg_writer w);
        return w.reg_write_enable && (w.reg_dest_addr != 5'd0);
    endfunction

    function automatic bit m_pri_hit();
        return pri_valid && m_writes(pri_writer);
    endfunction

    function automatic bit m_ready();
        return reset && (mq.size() < DEPTH);
    endfunction

    function automatic bit m_commit();
        return reset && !m_pri_hit() && (mq.size() != 0);
    endfunction

    function automatic logic [31:0] m_mask();
        logic [31:0] m;
        m = '0;
        foreach (mq[i]) m[mq[i].reg_dest_addr] = 1'b1;
        return m;
    endfunction

    function automatic reg_writer m_rf();
        reg_writer r;
        r = '0;
        if (reset) begin
            if (m_pri_hit())          r = pri_writer;
            else if (mq.size() != 0)  r = mq[0];
        end
        return r;
    endfunction

    function automatic bit m_stall();
        return unserved >= int'(MW);
    endfunction

    task automatic drive(input bit pv, input reg_writer pw, input bit sv, input reg_writer sw);
        pri_valid  = pv;
        pri_writer = pw;
        sec_valid  = sv;
        sec_writer = sw;
    endtask

    // Advance one clock and update the model from the inputs seen at that edge.
    task automatic tick();
        bit pop_m, push_m;
        pop_m  = m_commit();
        push_m = sec_valid && m_ready() && m_writes(sec_writer);
        @(posedge clk);
        if (!reset) begin
            mq.delete();
            unserved = 0;
        end else begin
            if (pop_m) begin
                void'(mq.pop_front());
                unserved = 0;
            end else if (mq.size() != 0) begin
                unserved++;
            end
            if (push_m) mq.push_back(sec_writer);
        end
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        drive(1'b1, mk(1, 4, rnd64()), 1'b1, mk(1, 6, rnd64()));
        repeat (3) tick();
        #1;
        n_checks++; if (sec_ready !== 1'b0) $display("FAIL reset_ready: got %b want 0", sec_ready); else n_pass++;
        n_checks++; if (rf_writer.reg_write_enable !== 1'b0) $display("FAIL reset_rf_en: got %b want 0", rf_writer.reg_write_enable); else n_pass++;
        n_checks++; if (sec_commit !== 1'b0) $display("FAIL reset_commit: got %b want 0", sec_commit); else n_pass++;
        n_checks++; if (pending_mask !== 32'h0) $display("FAIL reset_mask: got %h want 0", pending_mask); else n_pass++;
        n_checks++; if (stall_req !== 1'b0) $display("FAIL reset_stall: got %b want 0", stall_req); else n_pass++;
        reset = 1'b1;
        drive(1'b0, NOWR, 1'b0, NOWR);
        #1;
        n_checks++; if (sec_ready !== 1'b1) $display("FAIL release_ready: got %b want 1", sec_ready); else n_pass++;
        tick();
    endtask

    task automatic test_single_commit();
        reg_writer w;
        w = mk(1, 5, 64'hAA);
        drive(1'b0, NOWR, 1'b1, w);
        #1;
        n_checks++; if (sec_commit !== 1'b0) $display("FAIL single_no_bypass: got %b want 0", sec_commit); else n_pass++;
        tick();
        drive(1'b0, NOWR, 1'b0, NOWR);
        #1;
        n_checks++; if (rf_writer !== w) $display("FAIL single_rf: got %h want %h", rf_writer, w); else n_pass++;
        n_checks++; if (sec_commit !== 1'b1) $display("FAIL single_commit: got %b want 1", sec_commit); else n_pass++;
        n_checks++; if (pending_mask !== 32'h20) $display("FAIL single_mask_set: got %h want %h", pending_mask, 32'h20); else n_pass++;
        tick();
        #1;
        n_checks++; if (pending_mask !== 32'h0) $display("FAIL single_mask_clr: got %h want 0", pending_mask); else n_pass++;
        n_checks++; if (sec_commit !== 1'b0) $display("FAIL single_commit_clr: got %b want 0", sec_commit); else n_pass++;
    endtask

    task automatic test_starvation();
        reg_writer pw, e;
        pw = mk(1, 3, rnd64());
        e  = mk(1, 7, rnd64());
        drive(1'b1, pw, 1'b1, e);
        #1;
        n_checks++; if (rf_writer !== pw) $display("FAIL starve_pri_rf: got %h want %h", rf_writer, pw); else n_pass++;
        tick();
        drive(1'b1, pw, 1'b0, NOWR);
        for (int k = 1; k <= int'(MW) + 1; k++) begin
            #1;
            n_checks++;
            if (stall_req !== (k == int'(MW) + 1))
                $display("FAIL starve_stall cycle %0d: got %b want %b", k, stall_req, (k == int'(MW) + 1));
            else n_pass++;
            if (k != int'(MW) + 1) tick();
        end
        drive(1'b0, pw, 1'b0, NOWR);
        #1;
        n_checks++; if (rf_writer !== e) $display("FAIL starve_commit_rf: got %h want %h", rf_writer, e); else n_pass++;
        n_checks++; if (sec_commit !== 1'b1) $display("FAIL starve_commit: got %b want 1", sec_commit); else n_pass++;
        tick();
        #1;
        n_checks++; if (stall_req !== 1'b0) $display("FAIL starve_stall_fall: got %b want 0", stall_req); else n_pass++;
        n_checks++; if (pending_mask !== 32'h0) $display("FAIL starve_mask: got %h want 0", pending_mask); else n_pass++;
    endtask

    task automatic test_fill_order();
        reg_writer pw;
        reg_writer ent [4];
        pw = mk(1, 9, rnd64());
        for (int i = 0; i < 4; i++) begin
            ent[i] = mk(1, i + 1, rnd64());
            drive(1'b1, pw, 1'b1, ent[i]);
            #1;
            n_checks++; if (sec_ready !== 1'b1) $display("FAIL fill_ready %0d: got %b want 1", i, sec_ready); else n_pass++;
            tick();
        end
        drive(1'b1, pw, 1'b1, mk(1, 6, rnd64()));
        #1;
        n_checks++; if (sec_ready !== 1'b0) $display("FAIL fill_full_ready: got %b want 0", sec_ready); else n_pass++;
        n_checks++; if (pending_mask !== 32'h1E) $display("FAIL fill_mask: got %h want %h", pending_mask, 32'h1E); else n_pass++;
        tick();
        drive(1'b0, NOWR, 1'b0, NOWR);
        for (int i = 0; i < 4; i++) begin
            #1;
            n_checks++; if (rf_writer !== ent[i]) $display("FAIL fill_order %0d: got %h want %h", i, rf_writer, ent[i]); else n_pass++;
            n_checks++; if (sec_ready !== (i != 0)) $display("FAIL fill_ready_after_pop %0d: got %b want %b", i, sec_ready, (i != 0)); else n_pass++;
            tick();
        end
        #1;
        n_checks++; if (pending_mask !== 32'h0) $display("FAIL fill_mask_end: got %h want 0", pending_mask); else n_pass++;
    endtask

    task automatic test_full_push_pop();
        reg_writer pw;
        pw = mk(1, 20, rnd64());
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, pw, 1'b1, mk(1, 10 + i, rnd64()));
            #1;
            tick();
        end
        drive(1'b0, NOWR, 1'b1, mk(1, 14, rnd64()));
        #1;
        n_checks++; if (sec_ready !== 1'b0) $display("FAIL fullpp_ready: got %b want 0", sec_ready); else n_pass++;
        n_checks++; if (sec_commit !== 1'b1) $display("FAIL fullpp_commit: got %b want 1", sec_commit); else n_pass++;
        tick();
        #1;
        n_checks++; if (pending_mask !== 32'h3800) $display("FAIL fullpp_mask_refused: got %h want %h", pending_mask, 32'h3800); else n_pass++;
        drive(1'b0, NOWR, 1'b1, mk(1, 15, rnd64()));
        #1;
        n_checks++; if (sec_ready !== 1'b1) $display("FAIL three_pp_ready: got %b want 1", sec_ready); else n_pass++;
        tick();
        #1;
        n_checks++; if (pending_mask !== 32'hB000) $display("FAIL three_pp_mask: got %h want %h", pending_mask, 32'hB000); else n_pass++;
        n_checks++; if (sec_ready !== 1'b1) $display("FAIL three_pp_count: ready got %b want 1", sec_ready); else n_pass++;
        drive(1'b0, NOWR, 1'b0, NOWR);
        for (int g = 0; g < 8 && mq.size() != 0; g++) begin
            #1;
            n_checks++; if (rf_writer !== mq[0]) $display("FAIL three_pp_drain %0d: got %h want %h", g, rf_writer, mq[0]); else n_pass++;
            tick();
        end
        #1;
        n_checks++; if (pending_mask !== 32'h0) $display("FAIL three_pp_mask_end: got %h want 0", pending_mask); else n_pass++;
    endtask

    task automatic test_x0_drop();
        reg_writer e;
        drive(1'b1, mk(1, 0, rnd64()), 1'b1, mk(1, 0, rnd64()));
        #1;
        n_checks++; if (rf_writer.reg_write_enable !== 1'b0) $display("FAIL x0_pri_rf_en: got %b want 0", rf_writer.reg_write_enable); else n_pass++;
        n_checks++; if (sec_ready !== 1'b1) $display("FAIL x0_ready: got %b want 1", sec_ready); else n_pass++;
        tick();
        drive(1'b1, mk(0, 5, rnd64()), 1'b1, mk(0, 7, rnd64()));
        #1;
        n_checks++; if (pending_mask !== 32'h0) $display("FAIL x0_mask: got %h want 0", pending_mask); else n_pass++;
        n_checks++; if (rf_writer.reg_write_enable !== 1'b0) $display("FAIL dis_pri_rf_en: got %b want 0", rf_writer.reg_write_enable); else n_pass++;
        tick();
        e = mk(1, 8, rnd64());
        drive(1'b1, mk(1, 0, rnd64()), 1'b1, e);
        #1;
        n_checks++; if (pending_mask !== 32'h0) $display("FAIL dis_mask: got %h want 0", pending_mask); else n_pass++;
        tick();
        drive(1'b1, mk(1, 0, rnd64()), 1'b0, NOWR);
        #1;
        n_checks++; if (rf_writer !== e) $display("FAIL x0_pri_no_block: got %h want %h", rf_writer, e); else n_pass++;
        n_checks++; if (sec_commit !== 1'b1) $display("FAIL x0_pri_commit: got %b want 1", sec_commit); else n_pass++;
        tick();
    endtask

    task automatic test_random();
        logic [31:0]  pm;
        int unsigned  prd, srd;
        bit           pen, sen, pv, sv;
        reg_writer    exp_rf;
        for (int c = 0; c < 800; c++) begin
            pm  = m_mask();
            prd = $urandom_range(0, 31);
            for (int t = 0; t < 64 && pm[prd]; t++) prd = $urandom_range(0, 31);
            srd = $urandom_range(0, 31);
            for (int t = 0; t < 64 && pm[srd]; t++) srd = $urandom_range(0, 31);
            pen = ($urandom_range(0, 9) != 0) && !pm[prd];
            sen = ($urandom_range(0, 9) != 0) && !pm[srd];
            pv  = $urandom_range(0, 99) < (((c / 100) % 2 == 0) ? 88 : 40);
            sv  = $urandom_range(0, 99) < 45;
            reset = ($urandom_range(0, 199) != 0);
            drive(pv, mk(pen, prd, rnd64()), sv, mk(sen, srd, rnd64()));
            #1;
            exp_rf = m_rf();
            n_checks++;
            if (exp_rf.reg_write_enable ? (rf_writer !== exp_rf) : (rf_writer.reg_write_enable !== 1'b0))
                $display("FAIL rnd_rf cyc %0d: got %h want %h", c, rf_writer, exp_rf);
            else n_pass++;
            n_checks++; if (sec_ready !== m_ready()) $display("FAIL rnd_ready cyc %0d: got %b want %b", c, sec_ready, m_ready()); else n_pass++;
            n_checks++; if (sec_commit !== m_commit()) $display("FAIL rnd_commit cyc %0d: got %b want %b", c, sec_commit, m_commit()); else n_pass++;
            n_checks++; if (stall_req !== m_stall()) $display("FAIL rnd_stall cyc %0d: got %b want %b", c, stall_req, m_stall()); else n_pass++;
            n_checks++; if (pending_mask !== m_mask()) $display("FAIL rnd_mask cyc %0d: got %h want %h", c, pending_mask, m_mask()); else n_pass++;
            tick();
        end
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0;
        drive(1'b0, NOWR, 1'b0, NOWR);
        test_reset();
        test_single_commit();
        test_starvation();
        test_fill_order();
        test_full_push_pop();
        test_x0_drop();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
